// File: rtl/ascon_fc_pkg.sv
// Shared types and constants for the Ascon fault-countermeasure sequencer.
// The optional per-wait-state watchdog is enabled by defining FC_SEQ_WATCHDOG_EN.
package ascon_fc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_ENC,
    S_ENC_WAIT,
    S_DEC,
    S_DEC_WAIT,
    S_CHECK,
    S_RESP
  } fc_seq_state_t;

  localparam logic [1:0] FC_ST_OK       = 2'd0;
  localparam logic [1:0] FC_ST_MISMATCH = 2'd1;
  localparam logic [1:0] FC_ST_TIMEOUT  = 2'd2;

  localparam int FC_RETRY_W = 4;

  // True while the sequencer is waiting on a done flag from the FC wrapper.
  function automatic logic is_wait_state(input fc_seq_state_t s);
    return (s == S_ENC_WAIT) || (s == S_DEC_WAIT);
  endfunction

endpackage

// File: rtl/fc_seq_watchdog.sv
// Down-counter bounding how long the sequencer sits in one wait state.
// Only instantiated when FC_SEQ_WATCHDOG_EN is defined.
module fc_seq_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;

  // Reload on the cycle before a wait state, then count down while waiting.
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= CW'(TIMEOUT_CYCLES - 1);
    else if (enable && (cnt != '0))
      cnt <= cnt - 1'b1;
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/ascon_fc_sequencer.sv
// Sequences one Ascon job through the triplicated FC wrapper: clear, encrypt,
// decrypt the ciphertext, self-check, retry on mismatch, then respond.
// Define FC_SEQ_WATCHDOG_EN to bound each wait state with a timeout.
module ascon_fc_sequencer
  import ascon_fc_pkg::*;
#(
  parameter int Y              = 40,
  parameter int MAX_RETRY      = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [Y-1:0]          req_pt,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [Y-1:0]          resp_ct,
  output logic [127:0]          resp_tag,
  output logic [1:0]            resp_status,
  output logic [FC_RETRY_W-1:0] resp_retries,
  output logic                  core_rst,
  output logic [Y-1:0]          core_pt,
  output logic                  encryption_start,
  output logic                  decryption_start,
  input  logic                  encryption_ready,
  input  logic                  decryption_ready,
  input  logic [Y-1:0]          cipher_text,
  input  logic [127:0]          tag,
  input  logic [127:0]          dec_tag,
  input  logic [Y-1:0]          dec_plain_text
);

  localparam logic [FC_RETRY_W-1:0] MAX_R = FC_RETRY_W'(MAX_RETRY);

  fc_seq_state_t  state;
  logic [Y-1:0]   dpt_q;
  logic [127:0]   dtag_q;

`ifdef FC_SEQ_WATCHDOG_EN
  logic wd_expired;

  fc_seq_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wd (
    .clk    (clk),
    .rst    (rst),
    .load   ((state == S_ENC) || (state == S_DEC)),
    .enable (is_wait_state(state)),
    .expired(wd_expired)
  );
`endif

  // Main FSM; every output is a register so no input reaches an output combinationally.
  // resp_ct/resp_tag double as the encryption-result latches, so a mismatch
  // response naturally carries the last attempt's values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      req_ready        <= 1'b0;
      resp_valid       <= 1'b0;
      resp_ct          <= '0;
      resp_tag         <= '0;
      resp_status      <= FC_ST_OK;
      resp_retries     <= '0;
      core_rst         <= 1'b0;
      core_pt          <= '0;
      encryption_start <= 1'b0;
      decryption_start <= 1'b0;
      dpt_q            <= '0;
      dtag_q           <= '0;
    end else begin
      core_rst         <= 1'b0;
      encryption_start <= 1'b0;
      decryption_start <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (req_ready && req_valid) begin
            core_pt      <= req_pt;
            resp_retries <= '0;
            req_ready    <= 1'b0;
            core_rst     <= 1'b1;
            state        <= S_CLR;
          end else begin
            req_ready <= 1'b1;
          end
        end
        S_CLR: begin
          encryption_start <= 1'b1;
          state            <= S_ENC;
        end
        S_ENC: state <= S_ENC_WAIT;
        S_ENC_WAIT: begin
          if (encryption_ready) begin
            resp_ct          <= cipher_text;
            resp_tag         <= tag;
            decryption_start <= 1'b1;
            state            <= S_DEC;
          end
`ifdef FC_SEQ_WATCHDOG_EN
          else if (wd_expired) begin
            resp_status <= FC_ST_TIMEOUT;
            resp_valid  <= 1'b1;
            state       <= S_RESP;
          end
`endif
        end
        S_DEC: state <= S_DEC_WAIT;
        S_DEC_WAIT: begin
          if (decryption_ready) begin
            dpt_q  <= dec_plain_text;
            dtag_q <= dec_tag;
            state  <= S_CHECK;
          end
`ifdef FC_SEQ_WATCHDOG_EN
          else if (wd_expired) begin
            resp_status <= FC_ST_TIMEOUT;
            resp_valid  <= 1'b1;
            state       <= S_RESP;
          end
`endif
        end
        S_CHECK: begin
          if ((dpt_q == core_pt) && (dtag_q == resp_tag)) begin
            resp_status <= FC_ST_OK;
            resp_valid  <= 1'b1;
            state       <= S_RESP;
          end else if (resp_retries < MAX_R) begin
            resp_retries <= resp_retries + 1'b1;
            core_rst     <= 1'b1;
            state        <= S_CLR;
          end else begin
            resp_status <= FC_ST_MISMATCH;
            resp_valid  <= 1'b1;
            state       <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_fc_sequencer.sv
// Randomized self-checking bench for ascon_fc_sequencer with a behavioural FC
// wrapper model and a job-level reference for latency, status and results.
module tb_ascon_fc_sequencer;

  localparam int Y    = 40;
  localparam int MAXR = 2;
  localparam int TO   = 16;
  localparam logic [39:0] KEY = 40'h3C96A50F71;

  logic           clk = 1'b0;
  logic           rst;
  logic           req_valid, req_ready, resp_valid, resp_ready;
  logic [Y-1:0]   req_pt, resp_ct, core_pt;
  logic [127:0]   resp_tag;
  logic [1:0]     resp_status;
  logic [3:0]     resp_retries;
  logic           core_rst, encryption_start, decryption_start;
  logic           encryption_ready, decryption_ready;
  logic [Y-1:0]   cipher_text, dec_plain_text;
  logic [127:0]   tag, dec_tag;

  ascon_fc_sequencer #(.Y(Y), .MAX_RETRY(MAXR), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_pt(req_pt),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_ct(resp_ct),
    .resp_tag(resp_tag), .resp_status(resp_status), .resp_retries(resp_retries),
    .core_rst(core_rst), .core_pt(core_pt),
    .encryption_start(encryption_start), .decryption_start(decryption_start),
    .encryption_ready(encryption_ready), .decryption_ready(decryption_ready),
    .cipher_text(cipher_text), .tag(tag), .dec_tag(dec_tag),
    .dec_plain_text(dec_plain_text)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // ---------------- behavioural FC wrapper model ----------------
  function automatic logic [39:0] f_ct(input logic [39:0] p);
    return p ^ KEY;
  endfunction

  function automatic logic [127:0] f_tag(input logic [39:0] p);
    logic [47:0] m;
    m = 48'(p) * 48'd7 + 48'h1234;
    return {p ^ 40'h5A5A5A5A5A, m, 40'hC3C3C3C3C3 + p};
  endfunction

  // Fault config: attempts 1..k_cfg are faulty; mode 0 flips dec pt, 1 flips dec tag,
  // 2 corrupts the ciphertext bit (attempt % 40). ne/nd of 0 means never ready.
  int ne_cfg, nd_cfg, k_cfg, mode_cfg, job_base;
  int att = 0, n_crst = 0, n_es = 0, n_ds = 0;
  int ecnt = 0, dcnt = 0;

  function automatic bit cur_faulty();
    return (att - job_base) <= k_cfg;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      encryption_ready <= 1'b0; decryption_ready <= 1'b0;
      ecnt <= 0; dcnt <= 0;
      cipher_text <= '0; tag <= '0; dec_plain_text <= '0; dec_tag <= '0;
    end else if (core_rst) begin
      encryption_ready <= 1'b0; decryption_ready <= 1'b0;
      ecnt <= 0; dcnt <= 0;
      att <= att + 1; n_crst <= n_crst + 1;
    end else begin
      if (encryption_start) begin
        n_es <= n_es + 1;
        tag  <= f_tag(core_pt);
        cipher_text <= f_ct(core_pt) ^
          ((cur_faulty() && mode_cfg == 2) ? (40'd1 << ((att - job_base) % 40)) : 40'd0);
        if (ne_cfg == 1) encryption_ready <= 1'b1;
        else if (ne_cfg > 1) ecnt <= ne_cfg - 1;
      end else if (ecnt > 0) begin
        ecnt <= ecnt - 1;
        if (ecnt == 1) encryption_ready <= 1'b1;
      end
      if (decryption_start) begin
        n_ds <= n_ds + 1;
        dec_plain_text <= cipher_text ^ KEY ^
          ((cur_faulty() && mode_cfg == 0) ? 40'd1 : 40'd0);
        dec_tag <= tag ^ ((cur_faulty() && mode_cfg == 1) ? 128'd1 : 128'd0);
        if (nd_cfg == 1) decryption_ready <= 1'b1;
        else if (nd_cfg > 1) dcnt <= nd_cfg - 1;
      end else if (dcnt > 0) begin
        dcnt <= dcnt - 1;
        if (dcnt == 1) decryption_ready <= 1'b1;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk_reset_vals(input string nm);
    chk({nm, "_req_ready"}, req_ready, 0);
    chk({nm, "_resp_valid"}, resp_valid, 0);
    chk({nm, "_core_rst"}, core_rst, 0);
    chk({nm, "_starts"}, {encryption_start, decryption_start}, 0);
    chk({nm, "_core_pt"}, core_pt, 0);
    chk({nm, "_resp_data"}, {resp_ct, resp_tag[87:0]} ^ resp_tag, 0);
    chk({nm, "_status_retries"}, {resp_status, resp_retries}, 0);
  endtask

  // Offer one job, check response against the reference, handshake after rdly stall cycles.
  // With pend set, npt is offered during the stall and must be accepted right after it.
  task automatic run_job(input logic [39:0] pt, input int ne, input int nd, input int k,
                         input int md, input int rdly, input bit pend, input logic [39:0] npt);
    int w, a, r, s_crst, s_es, s_ds, bad;
    int exp_r, exp_lat;
    logic [1:0]   exp_st;
    logic [39:0]  exp_ct;
    logic [127:0] exp_tag;
    exp_r   = (k < MAXR) ? k : MAXR;
    exp_st  = (k > MAXR) ? 2'd1 : 2'd0;
    exp_lat = 5 + ne + nd + exp_r * (4 + ne + nd);
    exp_ct  = f_ct(pt) ^ ((md == 2 && k >= exp_r + 1) ? (40'd1 << ((exp_r + 1) % 40)) : 40'd0);
    exp_tag = f_tag(pt);
    ne_cfg = ne; nd_cfg = nd; k_cfg = k; mode_cfg = md; job_base = att;
    s_crst = n_crst; s_es = n_es; s_ds = n_ds;
    req_pt = pt; req_valid = 1'b1;
    chk("req_ready_on_offer", req_ready, 1);
    a = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    w = 0;
    while (!resp_valid && w < 2000) begin @(negedge clk); w++; end
    if (!resp_valid) begin
      chk("resp_valid_timeout", 0, 1);
      return;
    end
    r = cyc;
    chk("latency", r - a, exp_lat);
    chk("status", resp_status, exp_st);
    chk("retries", resp_retries, exp_r);
    chk("ct", resp_ct, exp_ct);
    chk("tag", resp_tag, exp_tag);
    chk("core_rst_pulses", n_crst - s_crst, exp_r + 1);
    chk("start_pairs", {16'(n_es - s_es), 16'(n_ds - s_ds)}, {16'(exp_r + 1), 16'(exp_r + 1)});
    if (pend) begin req_pt = npt; req_valid = 1'b1; end
    bad = 0;
    for (int i = 0; i < rdly; i++) begin
      @(negedge clk);
      if (!resp_valid || resp_ct !== exp_ct || resp_tag !== exp_tag ||
          resp_status !== exp_st || resp_retries !== 4'(exp_r) || req_ready) bad++;
    end
    chk("stall_stable", bad, 0);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("resp_valid_drop", resp_valid, 0);
    chk("req_ready_after_hs", req_ready, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    logic [39:0] cur, nxt;
    int w, a, s_crst, hi;
    bit pend;
    rst = 1'b1; req_valid = 1'b0; req_pt = '0; resp_ready = 1'b0;
    ne_cfg = 1; nd_cfg = 1; k_cfg = 0; mode_cfg = 0; job_base = 0;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("req_ready_post_reset", req_ready, 1);

    // Directed: nominal, single decryption fault, persistent fault, stall with pending request.
    run_job(40'h0123456789, 10, 10, 0, 0, 0, 1'b0, '0);
    run_job(40'hFEDCBA9876, 10, 10, 1, 0, 0, 1'b0, '0);
    run_job(40'h55AA55AA55, 6, 7, 5, 2, 0, 1'b0, '0);
    run_job(40'h13579BDF02, 4, 5, 0, 0, 20, 1'b1, 40'h2468ACE013);
    run_job(40'h2468ACE013, 3, 3, 3, 1, 2, 1'b0, '0);

    // Randomized jobs.
    cur = {8'($urandom), $urandom};
    for (int i = 0; i < 14; i++) begin
      nxt  = {8'($urandom), $urandom};
      pend = (i < 13) ? 1'($urandom_range(0, 1)) : 1'b0;
      run_job(cur, $urandom_range(1, 12), $urandom_range(1, 12), $urandom_range(0, 3),
              $urandom_range(0, 2), $urandom_range(0, 5), pend, nxt);
      if (!pend) repeat ($urandom_range(0, 3)) @(negedge clk);
      cur = nxt;
    end

    // Reset while waiting on decryption: job dropped, outputs back to reset values.
    ne_cfg = 3; nd_cfg = 30; k_cfg = 0; mode_cfg = 0; job_base = att;
    w = n_ds;
    req_pt = 40'h0F0F0F0F0F; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    a = 0;
    while (n_ds == w && a < 100) begin @(negedge clk); a++; end
    chk("reached_dec_wait", n_ds - w, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_vals("rst_in_dec_wait");
    rst = 1'b0;
    @(negedge clk);
    chk("req_ready_after_rst", req_ready, 1);
    hi = 0;
    repeat (60) begin @(negedge clk); if (resp_valid) hi++; end
    chk("no_resp_after_rst", hi, 0);

    // Encryption never completes.
    ne_cfg = 0; nd_cfg = 5; k_cfg = 0; mode_cfg = 0; job_base = att;
    s_crst = n_crst;
    req_pt = 40'h00000000FF; req_valid = 1'b1;
    chk("req_ready_timeout_job", req_ready, 1);
    a = cyc;
    @(negedge clk);
    req_valid = 1'b0;
`ifdef FC_SEQ_WATCHDOG_EN
    w = 0;
    while (!resp_valid && w < 200) begin @(negedge clk); w++; end
    chk("timeout_latency", cyc - a, 3 + TO);
    chk("timeout_status", resp_status, 2);
    chk("timeout_retries", resp_retries, 0);
    chk("timeout_core_rst", n_crst - s_crst, 1);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("timeout_hs", {resp_valid, req_ready}, 2'b01);
`else
    hi = 0;
    repeat (200) begin @(negedge clk); if (resp_valid) hi++; end
    chk("no_timeout_resp", hi, 0);
    chk("hang_core_rst", n_crst - s_crst, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("recover_after_hang", req_ready, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global guard against a stuck run.
  initial begin : guard
    #2000000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/ascon_fc_sequencer.md
# ascon_fc_sequencer

Controller that sequences one Ascon authenticated-encryption job through the fault-countermeasure wrapper (triplicated Encryption/Decryption cores with majority vote). For each accepted request it clears the cores, runs encryption, then decryption of the resulting ciphertext. It checks that decryption recovers the plaintext and tag, retries on mismatch, and returns ciphertext, tag and a status word over a valid/ready handshake. It sits between the host-side request interface and the FC wrapper's start/ready/data pins.

## Interface
Parameters:
- Y, 40, plaintext/ciphertext length in bits (matches the FC `y`)
- MAX_RETRY, 2, extra attempts after a failed self-check (0..15)
- TIMEOUT_CYCLES, 1024, watchdog limit per wait state (used only with the watchdog macro)

Ports (one clock `clk`; reset `rst` is synchronous, active-high):
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  host offers a job
- req_ready  out  1  sequencer can accept a job
- req_pt  in  Y  plaintext, captured on accept
- resp_valid  out  1  result available
- resp_ready  in  1  host consumes the result
- resp_ct  out  Y  ciphertext of the final attempt
- resp_tag  out  128  tag of the final attempt
- resp_status  out  2  0 OK, 1 MISMATCH, 2 TIMEOUT, 3 reserved
- resp_retries  out  4  retries used
- core_rst  out  1  reset pulse to the FC wrapper
- core_pt  out  Y  latched plaintext driven to the FC wrapper
- encryption_start / decryption_start  out  1  one-cycle start pulses
- encryption_ready / decryption_ready  in  1  level done flags from the FC wrapper
- cipher_text  in  Y  voted ciphertext
- tag / dec_tag  in  128  voted encryption and decryption tags
- dec_plain_text  in  Y  voted decrypted text

## Operation
- States: IDLE, CLR, ENC, ENC_WAIT, DEC, DEC_WAIT, CHECK, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: latch req_pt into core_pt, clear the retry count, go to CLR.
- CLR: core_rst=1 for exactly one cycle -> ENC.
- ENC: encryption_start=1 for one cycle -> ENC_WAIT.
- ENC_WAIT:
  - On encryption_ready=1: latch cipher_text and tag -> DEC.
- DEC: decryption_start=1 for one cycle -> DEC_WAIT.
- DEC_WAIT:
  - On decryption_ready=1: latch dec_plain_text and dec_tag -> CHECK.
- CHECK: pass means latched dec_plain_text == core_pt and latched dec_tag == latched tag.
  - Pass: status 0 -> RESP.
  - Fail with retry count < MAX_RETRY: increment the count -> CLR.
  - Fail otherwise: status 1 -> RESP.
- RESP:
  - resp_valid=1; resp_* are stable until resp_valid & resp_ready.
  - On handshake -> IDLE.
- On every MISMATCH response, resp_ct and resp_tag carry the last attempt's values.
- rst in any state:
  - Next state is IDLE; all registers cleared.
  - The in-flight job is dropped and no response is issued.
  - core_rst is not asserted by rst; the FC wrapper shares `rst`.

## Timing
- Reset values: req_ready=0 during the reset cycle, then 1 in IDLE. All other outputs are 0: resp_valid, resp_ct, resp_tag, resp_status, resp_retries, core_rst, core_pt, encryption_start, decryption_start.
- All outputs are registered or decoded from state only; there is no combinational path from any input to any output.
- Request handshake:
  - req_ready=1 only in IDLE.
  - There is a one-cycle bubble after the RESP handshake before the next accept.
- Latency from accept to resp_valid, single pass: 5 + Ne + Nd cycles.
  - Ne = cycles from encryption_start to encryption_ready.
  - Nd = cycles from decryption_start to decryption_ready.
- Each retry adds 4 + Ne + Nd cycles.
- A ready level already high on entry to a wait state is accepted on the first cycle of that state; CLR guarantees stale ready flags are cleared.

## Configuration
- FC_SEQ_WATCHDOG_EN defined:
  - A counter reloads to TIMEOUT_CYCLES-1 on entry to ENC_WAIT or DEC_WAIT and decrements each cycle in that state.
  - At 0 without ready: status 2 -> RESP, with no retry.
  - Ready in the same cycle as expiry wins: the data is latched and there is no timeout.
- FC_SEQ_WATCHDOG_EN undefined: the wait states block indefinitely, there is no counter logic, and status 2 is never produced.

## Structure
- Shared package `ascon_fc_pkg` holds:
  - the state enum `fc_seq_state_t`;
  - the status codes `FC_ST_OK`, `FC_ST_MISMATCH`, `FC_ST_TIMEOUT`;
  - the retry-count width constant.
- One sub-module, `fc_seq_watchdog` (load, enable, expired), instantiated only under FC_SEQ_WATCHDOG_EN.

## Test plan
- Nominal: accept pt=40'h0123456789 with a model FC (Ne=Nd=10) -> resp_valid after 25 cycles, status 0, retries 0, ct and tag equal to the model.
- One injected decryption fault (dec_plain_text bit 0 flipped on the first attempt only) -> exactly one extra core_rst pulse, status 0, retries 1.
- Persistent fault with MAX_RETRY=2 -> three start pairs, status 1, retries 2.
- With FC_SEQ_WATCHDOG_EN and TIMEOUT_CYCLES=16, encryption_ready never rises -> status 2 exactly 16 cycles after entering ENC_WAIT; without the macro, no response is issued.
- resp_ready held low for 20 cycles with a new req_valid pending -> resp_* stable, req_ready=0, next job accepted one cycle after the handshake.
- rst asserted during DEC_WAIT -> next cycle IDLE, all outputs at reset values, no resp_valid.
